// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_lsu
//  Description : RV32I load/store unit driving a word-wide data_mem port.
//                Byte/halfword loads are extracted and sign/zero-extended;
//                byte/halfword stores use read-modify-write. The core is
//                stalled until each access reaches DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_lsu #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wd,
    output logic [31:0] core_rd,
    output logic        core_stall,
    output logic        core_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam logic [2:0]  F3_B   = 3'b000;
    localparam logic [2:0]  F3_H   = 3'b001;
    localparam logic [2:0]  F3_W   = 3'b010;
    localparam logic [2:0]  F3_BU  = 3'b100;
    localparam logic [2:0]  F3_HU  = 3'b101;
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;
    logic        we_q,    we_d;
    logic [2:0]  size_q,  size_d;
    logic [1:0]  lane_q,  lane_d;

    logic        req_err;
    logic [31:0] merged_wd;
    logic [31:0] load_val;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Word-aligned memory address straight from the core address
    assign mem_addr = {core_addr[31:2], 2'b00};

    // Classify the incoming request as illegal (size, alignment, range)
    always_comb begin
        req_err = 1'b0;
        if ({1'b0, core_addr} >= ADDR_LIMIT) begin
            req_err = 1'b1;
        end
        if (core_we) begin
            case (core_size)
                F3_B:    ;
                F3_H:    if (core_addr[0])          req_err = 1'b1;
                F3_W:    if (core_addr[1:0] != 2'b00) req_err = 1'b1;
                default: req_err = 1'b1;
            endcase
        end else begin
            case (core_size)
                F3_B, F3_BU: ;
                F3_H, F3_HU: if (core_addr[0])          req_err = 1'b1;
                F3_W:        if (core_addr[1:0] != 2'b00) req_err = 1'b1;
                default:     req_err = 1'b1;
            endcase
        end
    end

    // Merge the store lane into the previously read word
    always_comb begin
        merged_wd = rdata_q;
        if (size_q == F3_H) begin
            merged_wd[{lane_q[1], 4'b0000} +: 16] = core_wd[15:0];
        end else begin
            merged_wd[{lane_q, 3'b000} +: 8] = core_wd[7:0];
        end
    end

    // Extract and extend the load lane from the captured word
    always_comb begin
        load_byte = rdata_q[{lane_q, 3'b000} +: 8];
        load_half = rdata_q[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            F3_B:    load_val = {{24{load_byte[7]}}, load_byte};
            F3_BU:   load_val = {24'd0, load_byte};
            F3_H:    load_val = {{16{load_half[15]}}, load_half};
            F3_HU:   load_val = {16'd0, load_half};
            F3_W:    load_val = rdata_q;
            default: load_val = 32'd0;
        endcase
    end

    // State register and captured access context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            lane_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            we_q    <= we_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
        end
    end

    // Next-state logic; the access context is latched when a request is accepted
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        we_d    = we_q;
        size_d  = size_q;
        lane_d  = lane_q;
        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    err_d   = req_err;
                    we_d    = core_we;
                    size_d  = core_size;
                    lane_d  = core_addr[1:0];
                    rdata_d = 32'd0;
                    if (req_err) begin
                        state_d = S_DONE;
                    end else if (!core_we) begin
                        state_d = S_LOAD;
                    end else if (core_size == F3_W) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = mem_rd;
                state_d = S_DONE;
            end
            S_STORE: begin
                state_d = S_DONE;
            end
            S_RMW_RD: begin
                rdata_d = mem_rd;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        mem_we  = 1'b0;
        mem_wd  = 32'd0;
        core_rd = 32'd0;
        core_err = 1'b0;
        case (state_q)
            S_STORE: begin
                mem_we = 1'b1;
                mem_wd = core_wd;
            end
            S_RMW_WR: begin
                mem_we = 1'b1;
                mem_wd = merged_wd;
            end
            S_DONE: begin
                core_err = err_q;
                if (!err_q && !we_q) begin
                    core_rd = load_val;
                end
            end
            default: ;
        endcase
        core_stall = ((state_q == S_IDLE) && core_req) ||
                     ((state_q != S_IDLE) && (state_q != S_DONE));
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_lsu
//  Description : Directed self-checking bench for data_mem_lsu with a
//                behavioural word memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_lsu;

    localparam int MEM_WORDS = 1024;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        core_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [MEM_WORDS];

    int n_checks = 0;
    int n_errors = 0;
    int n_outside_done = 0;

    data_mem_lsu #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_size  (core_size),
        .core_addr  (core_addr),
        .core_wd    (core_wd),
        .core_rd    (core_rd),
        .core_stall (core_stall),
        .core_err   (core_err),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data_mem: combinational read, write on rising edge
    assign mem_rd = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Runs one access starting just after a rising edge; returns results seen in DONE
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input bit keep,
                          output logic [31:0] rd, output logic err,
                          output int stalls, output int wes,
                          output logic [31:0] wr_addr, output logic [31:0] wr_data);
        bit done;
        core_req  = 1'b1;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = wd;
        stalls = 0; wes = 0; done = 0;
        rd = 32'hX; err = 1'bX; wr_addr = 32'd0; wr_data = 32'd0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (mem_we) begin
                wes++;
                wr_addr = mem_addr;
                wr_data = mem_wd;
            end
            if (core_stall) begin
                stalls++;
                if (core_rd !== 32'd0 || core_err !== 1'b0) n_outside_done++;
            end else begin
                rd   = core_rd;
                err  = core_err;
                done = 1;
            end
        end
        check("access_completes", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        if (!keep) core_req = 1'b0;
    endtask

    logic [31:0] rd, wa, wdat;
    logic        err;
    int          st, we_n;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        string       tag;
    } err_vec_t;

    err_vec_t evec [5];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'd0;
        mem[32'h20 >> 2] = 32'h11223344;
        mem[32'h30 >> 2] = 32'hCAFEF00D;
        evec[0] = '{1'b0, 3'b010, 32'h0000_0013, "err_lw_misaligned"};
        evec[1] = '{1'b1, 3'b001, 32'h0000_0021, "err_sh_odd"};
        evec[2] = '{1'b0, 3'b011, 32'h0000_0000, "err_load_size011"};
        evec[3] = '{1'b0, 3'b010, 32'h0000_1000, "err_out_of_range"};
        evec[4] = '{1'b1, 3'b100, 32'h0000_0004, "err_store_size100"};

        rst = 1'b1; core_req = 1'b0; core_we = 1'b0;
        core_size = 3'b000; core_addr = 32'd0; core_wd = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("reset_stall", {31'd0, core_stall}, 32'd0);
        check("reset_core_rd", core_rd, 32'd0);
        check("reset_core_err", {31'd0, core_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // SW then LW of a full word
        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, err, st, we_n, wa, wdat);
        check("sw_stall", st, 2);
        check("sw_we_pulses", we_n, 1);
        check("sw_wr_addr", wa, 32'h10);
        check("sw_wr_data", wdat, 32'hDEADBEEF);
        check("sw_err", {31'd0, err}, 32'd0);
        access(1'b0, 3'b010, 32'h10, 32'd0, 0, rd, err, st, we_n, wa, wdat);
        check("lw_rd", rd, 32'hDEADBEEF);
        check("lw_stall", st, 2);
        check("lw_no_we", we_n, 0);

        // SB read-modify-write then byte loads
        access(1'b1, 3'b000, 32'h21, 32'h000000AA, 0, rd, err, st, we_n, wa, wdat);
        check("sb_stall", st, 3);
        check("sb_we_pulses", we_n, 1);
        check("sb_wr_addr", wa, 32'h20);
        check("sb_wr_data", wdat, 32'h1122AA44);
        access(1'b0, 3'b100, 32'h21, 32'd0, 0, rd, err, st, we_n, wa, wdat);
        check("lbu_rd", rd, 32'h000000AA);
        access(1'b0, 3'b000, 32'h21, 32'd0, 0, rd, err, st, we_n, wa, wdat);
        check("lb_rd", rd, 32'hFFFFFFAA);
        access(1'b0, 3'b000, 32'h20, 32'd0, 0, rd, err, st, we_n, wa, wdat);
        check("lb_lane0_pos", rd, 32'h00000044);

        // SH onto the upper half, then halfword loads
        access(1'b1, 3'b001, 32'h22, 32'h00008001, 0, rd, err, st, we_n, wa, wdat);
        check("sh_stall", st, 3);
        check("sh_wr_data", wdat, 32'h8001AA44);
        access(1'b0, 3'b001, 32'h22, 32'd0, 0, rd, err, st, we_n, wa, wdat);
        check("lh_rd", rd, 32'hFFFF8001);
        access(1'b0, 3'b101, 32'h22, 32'd0, 0, rd, err, st, we_n, wa, wdat);
        check("lhu_rd", rd, 32'h00008001);

        // Illegal accesses
        for (int i = 0; i < 5; i++) begin
            access(evec[i].we, evec[i].size, evec[i].addr, 32'hFFFFFFFF, 0, rd, err, st, we_n, wa, wdat);
            check({evec[i].tag, "_err"}, {31'd0, err}, 32'd1);
            check({evec[i].tag, "_rd"}, rd, 32'd0);
            check({evec[i].tag, "_we"}, we_n, 0);
            check({evec[i].tag, "_stall"}, st, 1);
        end
        // Last in-range word is legal
        access(1'b0, 3'b010, 32'hFFC, 32'd0, 0, rd, err, st, we_n, wa, wdat);
        check("last_word_err", {31'd0, err}, 32'd0);
        check("untouched_word_after_sh_err", mem[32'h20 >> 2], 32'h8001AA44);

        // Reset while in RMW_RD of an SB: no write may happen
        core_req = 1'b1; core_we = 1'b1; core_size = 3'b000;
        core_addr = 32'h30; core_wd = 32'h00000055;
        @(posedge clk); #1;
        check("rmw_rd_stall", {31'd0, core_stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_stall_follows_req", {31'd0, core_stall}, 32'd1);
        core_req = 1'b0;
        #1;
        check("rst_stall_no_req", {31'd0, core_stall}, 32'd0);
        we_n = 0;
        repeat (2) begin
            @(negedge clk);
            if (mem_we) we_n++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_no_write", we_n, 0);
        access(1'b0, 3'b010, 32'h30, 32'd0, 0, rd, err, st, we_n, wa, wdat);
        check("rst_word_unchanged", rd, 32'hCAFEF00D);

        // Back-to-back with core_req held high
        access(1'b1, 3'b010, 32'h40, 32'h12345678, 1, rd, err, st, we_n, wa, wdat);
        check("b2b_sw_stall", st, 2);
        check("b2b_sw_we", we_n, 1);
        access(1'b0, 3'b010, 32'h40, 32'd0, 1, rd, err, st, we_n, wa, wdat);
        check("b2b_lw_rd", rd, 32'h12345678);
        check("b2b_lw_stall", st, 2);
        check("b2b_lw_we", we_n, 0);
        access(1'b1, 3'b000, 32'h41, 32'h00000099, 1, rd, err, st, we_n, wa, wdat);
        check("b2b_sb_stall", st, 3);
        check("b2b_sb_wr_data", wdat, 32'h12349978);
        access(1'b0, 3'b100, 32'h41, 32'd0, 0, rd, err, st, we_n, wa, wdat);
        check("b2b_lbu_rd", rd, 32'h00000099);
        check("b2b_lbu_stall", st, 2);
        check("b2b_lbu_we", we_n, 0);

        check("rd_err_zero_outside_done", n_outside_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
